// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's IF/MEM requesters, the arbiter and the
// single-ported byte-addressed memory.
interface mem_port_arbiter_if #(
    parameter int AW = 8
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_func3;
    logic          d_ready;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          stall;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_func3;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_read, d_write, d_addr, d_wdata, d_func3,
        input  mem_rdata,
        output if_ready, if_instr,
        output d_ready, d_rdata, d_err, stall,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_func3
    );

    modport master (
        output if_req, if_addr,
        output d_read, d_write, d_addr, d_wdata, d_func3,
        output mem_rdata,
        input  if_ready, if_instr,
        input  d_ready, d_rdata, d_err, stall,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_func3
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a unified single-ported memory.
// Every access runs IDLE -> ISSUE -> RESP; bad sizes/alignments short-cut via ERR_D.
module mem_port_arbiter #(
    parameter int AW           = 8,
    parameter int MAX_DATA_RUN = 3,
    parameter int CHECK_ALIGN  = 1
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int RW = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE_I, ISSUE_D, RESP_I, RESP_D, ERR_D
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    func3_q, func3_d;
    logic          store_q, store_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   rdata_q, rdata_d;

    logic d_req;
    logic bad_code;
    logic misaligned;
    logic fetch_wins;
    logic if_rdy;
    logic d_rdy;

    always_comb begin
        d_req    = bus.d_read | bus.d_write;
        bad_code = (bus.d_func3[1:0] == 2'b11)
                 | (bus.d_func3[2] & bus.d_func3[1])
                 | (bus.d_write & bus.d_func3[2]);
        misaligned = (CHECK_ALIGN != 0) &&
                     (((bus.d_func3[1:0] == 2'b01) && bus.d_addr[0]) ||
                      ((bus.d_func3[1:0] == 2'b10) && (bus.d_addr[1:0] != 2'b00)));
        fetch_wins = bus.if_req && (run_q == RW'(MAX_DATA_RUN));
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        store_d = store_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        if_rdy  = 1'b0;
        d_rdy   = 1'b0;

        bus.d_err     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_func3 = '0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !fetch_wins) begin
                    state_d = (bad_code || misaligned) ? ERR_D : ISSUE_D;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    func3_d = bus.d_func3;
                    store_d = bus.d_write;
                    run_d   = bus.if_req ? run_q + RW'(1) : '0;
                end else if (bus.if_req) begin
                    state_d = ISSUE_I;
                    addr_d  = bus.if_addr;
                    run_d   = '0;
                end else begin
                    run_d = '0;
                end
            end
            ISSUE_I: begin
                bus.mem_read  = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_func3 = 3'b010;
                state_d       = RESP_I;
            end
            ISSUE_D: begin
                bus.mem_read  = ~store_q;
                bus.mem_write = store_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = store_q ? wdata_q : '0;
                bus.mem_func3 = func3_q;
                state_d       = RESP_D;
            end
            RESP_I: begin
                if_rdy  = 1'b1;
                instr_d = bus.mem_rdata;
                state_d = IDLE;
            end
            RESP_D: begin
                d_rdy   = 1'b1;
                rdata_d = store_q ? '0 : bus.mem_rdata;
                state_d = IDLE;
            end
            ERR_D: begin
                d_rdy     = 1'b1;
                bus.d_err = 1'b1;
                rdata_d   = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready data is forwarded in the RESP cycle and held afterwards.
    assign bus.if_ready = if_rdy;
    assign bus.d_ready  = d_rdy;
    assign bus.if_instr = instr_d;
    assign bus.d_rdata  = rdata_d;
    assign bus.stall    = rst_n & ((bus.if_req & ~if_rdy) | (d_req & ~d_rdy));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            store_q <= 1'b0;
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            store_q <= store_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus corner sequences.
// A small byte memory model answers the arbiter's memory port.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(8)) bus_if ();

    mem_port_arbiter #(
        .AW(8),
        .MAX_DATA_RUN(3),
        .CHECK_ALIGN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] mem [0:255];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [31:0] w_data;
    logic [2:0]  w_f3;

    function automatic logic [31:0] rd_fn(input logic [7:0] a, input logic [2:0] f);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 8'd1];
        b2 = mem[a + 8'd2];
        b3 = mem[a + 8'd3];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h04] <= 8'h83;
            mem[8'h05] <= 8'h20;
            mem[8'h06] <= 8'h80;
            mem[8'h07] <= 8'h0c;
            mem[8'hC8] <= 8'hE5;
            mem[8'hC9] <= 8'hF0;
            mem[8'hCA] <= 8'h01;
            mem[8'hCB] <= 8'h80;
        end else begin
            if (bus_if.mem_write) begin
                mem[bus_if.mem_addr] <= bus_if.mem_wdata[7:0];
                if (bus_if.mem_func3[1:0] != 2'b00)
                    mem[bus_if.mem_addr + 8'd1] <= bus_if.mem_wdata[15:8];
                if (bus_if.mem_func3[1:0] == 2'b10) begin
                    mem[bus_if.mem_addr + 8'd2] <= bus_if.mem_wdata[23:16];
                    mem[bus_if.mem_addr + 8'd3] <= bus_if.mem_wdata[31:24];
                end
            end
            if (bus_if.mem_read)
                bus_if.mem_rdata <= rd_fn(bus_if.mem_addr, bus_if.mem_func3);
        end
    end

    always @(negedge clk) begin
        if (bus_if.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus_if.mem_write) begin
            wr_cnt <= wr_cnt + 1;
            w_data <= bus_if.mem_wdata;
            w_f3   <= bus_if.mem_func3;
        end
        if (bus_if.mem_read && bus_if.mem_write) both_cnt <= both_cnt + 1;
    end

    // Runs n cycles; requesters drop their request the cycle after ready unless held.
    task automatic run(input int n, input bit hold,
                       output int dcyc, output int icyc,
                       output logic [31:0] dr, output logic [31:0] ir,
                       output logic derr, output int sbad,
                       output logic [7:0] ord, output int nrdy);
        bit dseen, iseen;
        logic es;
        dcyc = -1; icyc = -1; dr = '0; ir = '0; derr = 1'b0;
        sbad = 0; ord = '0; nrdy = 0; dseen = 0; iseen = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (dseen && !hold) begin
                bus_if.d_read  = 1'b0;
                bus_if.d_write = 1'b0;
            end
            if (iseen && !hold) bus_if.if_req = 1'b0;
            dseen = 0;
            iseen = 0;
            @(negedge clk);
            es = (bus_if.if_req & ~bus_if.if_ready) |
                 ((bus_if.d_read | bus_if.d_write) & ~bus_if.d_ready);
            if (bus_if.stall !== es) sbad++;
            if (bus_if.d_ready) begin
                dseen = 1;
                if (dcyc < 0) dcyc = k;
                dr = bus_if.d_rdata;
                derr = bus_if.d_err;
                if (nrdy < 8) ord[nrdy] = 1'b0;
                nrdy++;
            end
            if (bus_if.if_ready) begin
                iseen = 1;
                if (icyc < 0) icyc = k;
                ir = bus_if.if_instr;
                if (nrdy < 8) ord[nrdy] = 1'b1;
                nrdy++;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, {bus_if.if_ready, bus_if.d_ready, bus_if.d_err, bus_if.stall,
                            bus_if.mem_read, bus_if.mem_write, bus_if.mem_func3,
                            bus_if.mem_addr}, 64'h0);
        chk({tag, " data"}, {bus_if.if_instr, bus_if.d_rdata}, 64'h0);
        chk({tag, " wdata"}, bus_if.mem_wdata, 64'h0);
    endtask

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp;
        bit          err;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vt [16];

    initial begin
        int dcyc, icyc, sbad, nrdy, r0, w0;
        logic [31:0] dr, ir;
        logic derr;
        logic [7:0] ord;

        // kind: 0 fetch, 1 load, 2 store, 3 read+write (store)
        vt[0]  = '{0, 8'h04, 32'h0,        3'b010, 32'h0c802083, 0, 1, 0};
        vt[1]  = '{1, 8'hC8, 32'h0,        3'b010, 32'h8001F0E5, 0, 1, 0};
        vt[2]  = '{1, 8'hC8, 32'h0,        3'b000, 32'hFFFFFFE5, 0, 1, 0};
        vt[3]  = '{1, 8'hC8, 32'h0,        3'b100, 32'h000000E5, 0, 1, 0};
        vt[4]  = '{1, 8'hCA, 32'h0,        3'b001, 32'hFFFF8001, 0, 1, 0};
        vt[5]  = '{1, 8'hCA, 32'h0,        3'b101, 32'h00008001, 0, 1, 0};
        vt[6]  = '{2, 8'hCC, 32'h2A,       3'b010, 32'h0,        0, 0, 1};
        vt[7]  = '{1, 8'hCC, 32'h0,        3'b010, 32'h0000002A, 0, 1, 0};
        vt[8]  = '{1, 8'hC9, 32'h0,        3'b010, 32'h0,        1, 0, 0};
        vt[9]  = '{2, 8'hC9, 32'h1234,     3'b001, 32'h0,        1, 0, 0};
        vt[10] = '{1, 8'hC8, 32'h0,        3'b011, 32'h0,        1, 0, 0};
        vt[11] = '{2, 8'hCD, 32'h1234567F, 3'b000, 32'h0,        0, 0, 1};
        vt[12] = '{1, 8'hCC, 32'h0,        3'b010, 32'h00007F2A, 0, 1, 0};
        vt[13] = '{2, 8'hCC, 32'h99,       3'b100, 32'h0,        1, 0, 0};
        vt[14] = '{3, 8'hD4, 32'h12345678, 3'b010, 32'h0,        0, 0, 1};
        vt[15] = '{1, 8'hD4, 32'h0,        3'b010, 32'h12345678, 0, 1, 0};

        rst_n = 1'b0;
        bus_if.if_req = 1'b0;
        bus_if.if_addr = '0;
        bus_if.d_read = 1'b0;
        bus_if.d_write = 1'b0;
        bus_if.d_addr = '0;
        bus_if.d_wdata = '0;
        bus_if.d_func3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        // Fetch only, cycle-exact
        @(posedge clk); #1;
        bus_if.if_req = 1'b1;
        bus_if.if_addr = 8'h04;
        r0 = rd_cnt;
        @(negedge clk);
        @(negedge clk);
        chk("fo issue", {bus_if.mem_read, bus_if.mem_write, bus_if.mem_addr, bus_if.mem_func3},
            {1'b1, 1'b0, 8'h04, 3'b010});
        @(negedge clk);
        chk("fo ready", {bus_if.if_ready, bus_if.if_instr}, {1'b1, 32'h0c802083});
        @(posedge clk); #1;
        bus_if.if_req = 1'b0;
        @(negedge clk);
        chk("fo drop", {bus_if.if_ready, bus_if.mem_read}, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("fo grants", rd_cnt - r0, 1);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            r0 = rd_cnt;
            w0 = wr_cnt;
            bus_if.d_addr  = vt[i].addr;
            bus_if.d_wdata = vt[i].wdata;
            bus_if.d_func3 = vt[i].f3;
            case (vt[i].kind)
                0: begin
                    bus_if.if_req  = 1'b1;
                    bus_if.if_addr = vt[i].addr;
                end
                1: bus_if.d_read = 1'b1;
                2: bus_if.d_write = 1'b1;
                default: begin
                    bus_if.d_read  = 1'b1;
                    bus_if.d_write = 1'b1;
                end
            endcase
            run(6, 0, dcyc, icyc, dr, ir, derr, sbad, ord, nrdy);
            #1;
            if (vt[i].kind == 0) begin
                chk($sformatf("vec%0d instr", i), ir, vt[i].exp);
                chk($sformatf("vec%0d lat", i), icyc, 2);
            end else begin
                chk($sformatf("vec%0d rdata", i), dr, vt[i].exp);
                chk($sformatf("vec%0d err", i), derr, vt[i].err);
                chk($sformatf("vec%0d lat", i), dcyc, vt[i].err ? 1 : 2);
            end
            chk($sformatf("vec%0d nrd", i), rd_cnt - r0, vt[i].nrd);
            chk($sformatf("vec%0d nwr", i), wr_cnt - w0, vt[i].nwr);
            chk($sformatf("vec%0d nrdy", i), nrdy, 1);
            chk($sformatf("vec%0d stall", i), sbad, 0);
            if (vt[i].nwr != 0) begin
                chk($sformatf("vec%0d wdata", i), w_data, vt[i].wdata);
                chk($sformatf("vec%0d wf3", i), w_f3, vt[i].f3);
            end
        end

        // Simultaneous fetch and load: data first
        @(posedge clk); #1;
        bus_if.if_req = 1'b1;
        bus_if.if_addr = 8'h04;
        bus_if.d_read = 1'b1;
        bus_if.d_addr = 8'hC8;
        bus_if.d_func3 = 3'b010;
        run(8, 0, dcyc, icyc, dr, ir, derr, sbad, ord, nrdy);
        chk("sim dcyc", dcyc, 2);
        chk("sim icyc", icyc, 5);
        chk("sim rdata", dr, 32'h8001F0E5);
        chk("sim instr", ir, 32'h0c802083);
        chk("sim order", {nrdy[3:0], ord}, {4'd2, 8'b0000_0010});
        chk("sim stall", sbad, 0);

        // Fairness with both requesters held
        @(posedge clk); #1;
        bus_if.if_req = 1'b1;
        bus_if.d_read = 1'b1;
        run(24, 1, dcyc, icyc, dr, ir, derr, sbad, ord, nrdy);
        bus_if.if_req = 1'b0;
        bus_if.d_read = 1'b0;
        chk("fair order", ord, 8'b1000_1000);
        chk("fair nrdy", nrdy, 8);
        chk("fair stall", sbad, 0);
        repeat (3) @(posedge clk);

        // Reset during ISSUE_D of a store
        #1;
        bus_if.d_write = 1'b1;
        bus_if.d_addr = 8'hD0;
        bus_if.d_wdata = 32'h55;
        bus_if.d_func3 = 3'b010;
        bus_if.if_req = 1'b1;
        bus_if.if_addr = 8'h04;
        @(negedge clk);
        @(negedge clk);
        chk("rm issue", {bus_if.mem_write, bus_if.mem_read}, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("rm");
        rst_n = 1'b1;
        bus_if.d_write = 1'b0;
        run(5, 0, dcyc, icyc, dr, ir, derr, sbad, ord, nrdy);
        chk("rm no dready", dcyc, -1);
        chk("rm icyc", icyc, 2);
        chk("rm instr", ir, 32'h0c802083);
        #1;
        chk("never both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
